mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/arb_timeout_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter: FSM
// encoding, default starvation/timeout limits and the arbitration rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Default number of consecutive DM grants tolerated while IF waits.
  localparam int STARVE_MAX_DEF = 4;

  // Default number of cycles the memory gets to raise its ack.
  localparam int TIMEOUT_DEF = 16;

  // Width of the starvation counter; must hold STARVE_MAX.
  localparam int STARVE_W = 3;

  // DM normally wins a tie, except when IF has already been passed over
  // STARVE_MAX times in a row.
  function automatic logic pick_dm(input logic if_req,
                                   input logic dm_req,
                                   input logic starved);
    return dm_req && !(if_req && starved);
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog for one memory transaction: counts cycles spent waiting for the
// memory ack and flags expiry once TIMEOUT-1 is reached.
module arb_timeout_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Hold at zero while cleared, otherwise count waiting cycles and stop at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data-memory port onto one
// shared memory port. DM has priority, bounded by a starvation counter so
// IF is guaranteed a slot; a watchdog ends transactions the memory never acks.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  logic                dm_wins;
  logic                in_grant;
  logic                granted_dm;
  logic                tmo_expired;

  assign starved    = (starve_cnt == STARVE_LIMIT);
  assign dm_wins    = pick_dm(if_req_i, dm_req_i, starved);
  assign in_grant   = (state == GNT_IF) || (state == GNT_DM);
  assign granted_dm = (state == GNT_DM);

  // The watchdog sits at zero outside a grant, so every grant starts fresh,
  // and it only advances on cycles the memory has not acked.
  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (!in_grant),
    .enable (in_grant && !mem_ack_i),
    .expired(tmo_expired)
  );

  // Arbitration FSM; every output is registered here so the memory port and
  // the requester acks change only on clock edges (or on reset).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      err_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dm_wins) begin
            state       <= GNT_DM;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            if (if_req_i && !starved) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end else if (if_req_i) begin
            state       <= GNT_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            starve_cnt  <= '0;
          end
        end
        GNT_IF, GNT_DM: begin
          if (mem_ack_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (granted_dm) begin
              dm_ack_o <= 1'b1;
              if (!mem_we_o) begin
                dm_rdata_o <= mem_rdata_i;
              end
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end
          end else if (tmo_expired) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            err_o     <= 1'b1;
            if (granted_dm) begin
              dm_ack_o <= 1'b1;
            end else begin
              if_ack_o <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are
// inspected on the falling clock edge, half a cycle away from the DUT edge.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TIMEOUT   (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_rdata_o (if_rdata_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_ack_o   (dm_ack_o),
    .dm_rdata_o (dm_rdata_o),
    .err_o      (err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i)
  );

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Memory responder: waits (bounded) for mem_req_o, records the request,
  // raises mem_ack_i 'delay' cycles after the cycle mem_req_o rose, and
  // returns on the falling edge where the requester ack should be visible.
  task automatic serve(input logic [31:0] rdata, input int delay,
                       output logic [31:0] addr, output logic we,
                       output logic [31:0] wdata, output bit ok);
    int n;
    ok    = 1'b0;
    n     = 0;
    addr  = '0;
    we    = 1'b0;
    wdata = '0;
    while (mem_req_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (mem_req_o !== 1'b1) return;
    addr  = mem_addr_o;
    we    = mem_we_o;
    wdata = mem_wdata_o;
    repeat (delay) tick();
    mem_ack_i   = 1'b1;
    mem_rdata_i = rdata;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    repeat (2) tick();
    total++;
    if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, err_o} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, err_o});
    end
    total++;
    if ({if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o} !== 128'b0) begin
      bad++;
      $display("[TB] FAIL reset_data: if_rdata=%h dm_rdata=%h addr=%h wdata=%h expected all 0",
               if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o);
    end
    rst_i = 1'b0;
    repeat (2) tick();
    total++;
    if (mem_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_no_req: mem_req_o=%b expected 0", mem_req_o);
    end
  endtask

  task automatic test_if_read();
    logic [31:0] addr, wdata;
    logic        we;
    bit          ok;
    int          extra;
    if_addr_i = 32'h10;
    if_req_i  = 1'b1;
    serve(32'hDEADBEEF, 2, addr, we, wdata, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL if_read_grant: mem_req_o never rose, expected a grant");
    end
    total++;
    if (addr !== 32'h10 || we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL if_read_req: addr=%h we=%b expected 00000010/0", addr, we);
    end
    total++;
    if ({if_ack_o, dm_ack_o, err_o} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL if_read_ack: if/dm/err=%b expected 100", {if_ack_o, dm_ack_o, err_o});
    end
    total++;
    if (if_rdata_o !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL if_read_data: got %h expected deadbeef", if_rdata_o);
    end
    if_req_i = 1'b0;
    extra = 0;
    repeat (5) begin
      tick();
      if (if_ack_o === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("[TB] FAIL if_read_single_pulse: %0d extra ack cycles, expected 0", extra);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] addr, wdata;
    logic        we;
    bit          ok;
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h40;
    dm_wdata_i = 32'h1234;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h80;
    serve(32'hBADBAD00, 1, addr, we, wdata, ok);
    total++;
    if (!ok || addr !== 32'h40 || we !== 1'b1 || wdata !== 32'h1234) begin
      bad++;
      $display("[TB] FAIL tie_dm_first: ok=%0d addr=%h we=%b wdata=%h expected 1/00000040/1/00001234",
               ok, addr, we, wdata);
    end
    total++;
    if ({dm_ack_o, if_ack_o, err_o, mem_req_o} !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL tie_dm_ack: dm/if/err/req=%b expected 1000",
               {dm_ack_o, if_ack_o, err_o, mem_req_o});
    end
    total++;
    if (dm_rdata_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL write_keeps_rdata: dm_rdata_o=%h expected 00000000", dm_rdata_o);
    end
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
    serve(32'h0000CAFE, 1, addr, we, wdata, ok);
    total++;
    if (!ok || addr !== 32'h80 || we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tie_if_second: ok=%0d addr=%h we=%b expected 1/00000080/0", ok, addr, we);
    end
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h0000CAFE) begin
      bad++;
      $display("[TB] FAIL tie_if_ack: ack=%b rdata=%h expected 1/0000cafe", if_ack_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    logic [31:0] addr, wdata, exp_addr, exp_data;
    logic        we;
    bit          ok;
    bit          exp_dm;
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h100;
    for (int k = 0; k < 6; k++) begin
      exp_data = 32'hA000_0000 + 32'(k);
      exp_dm   = (k != 4);
      exp_addr = exp_dm ? (32'h100 + 32'(k)) : 32'h200;
      serve(exp_data, 1, addr, we, wdata, ok);
      total++;
      if (!ok || addr !== exp_addr) begin
        bad++;
        $display("[TB] FAIL starve_grant_%0d: ok=%0d addr=%h expected %h", k, ok, addr, exp_addr);
      end
      total++;
      if (exp_dm && (dm_ack_o !== 1'b1 || dm_rdata_o !== exp_data)) begin
        bad++;
        $display("[TB] FAIL starve_dm_ack_%0d: ack=%b rdata=%h expected 1/%h", k, dm_ack_o, dm_rdata_o, exp_data);
      end else if (!exp_dm && (if_ack_o !== 1'b1 || if_rdata_o !== exp_data)) begin
        bad++;
        $display("[TB] FAIL starve_if_ack_%0d: ack=%b rdata=%h expected 1/%h", k, if_ack_o, if_rdata_o, exp_data);
      end
      if (k == 3) begin
        total++;
        if (dut.starve_cnt !== 3'd4) begin
          bad++;
          $display("[TB] FAIL starve_cnt_sat: got %0d expected 4", dut.starve_cnt);
        end
      end
      if (k == 4) begin
        total++;
        if (dut.starve_cnt !== 3'd0) begin
          bad++;
          $display("[TB] FAIL starve_cnt_clear: got %0d expected 0", dut.starve_cnt);
        end
      end
      dm_addr_i = 32'h100 + 32'(k + 1);
    end
    dm_req_i = 1'b0;
    serve(32'h5A5A5A5A, 1, addr, we, wdata, ok);
    total++;
    if (!ok || addr !== 32'h200 || if_ack_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL starve_if_tail: ok=%0d addr=%h ack=%b expected 1/00000200/1", ok, addr, if_ack_o);
    end
    if_req_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int n;
    bit early;
    bit stray;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h300;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_grant: mem_req_o=%b expected 1", mem_req_o);
    end
    early = 1'b0;
    repeat (15) begin
      tick();
      if (dm_ack_o === 1'b1 || err_o === 1'b1) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("[TB] FAIL timeout_early: ack or err before cycle 16, expected none");
    end
    tick();
    total++;
    if ({err_o, dm_ack_o, if_ack_o, mem_req_o} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL timeout_resp: err/dm/if/req=%b expected 1100",
               {err_o, dm_ack_o, if_ack_o, mem_req_o});
    end
    total++;
    if (dm_rdata_o !== 32'hA000_0005) begin
      bad++;
      $display("[TB] FAIL timeout_rdata: got %h expected a0000005", dm_rdata_o);
    end
    dm_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    stray = 1'b0;
    repeat (3) begin
      tick();
      if (dm_ack_o === 1'b1 || if_ack_o === 1'b1 || err_o === 1'b1 || mem_req_o === 1'b1) stray = 1'b1;
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    total++;
    if (stray || dm_rdata_o !== 32'hA000_0005) begin
      bad++;
      $display("[TB] FAIL late_ack_ignored: stray=%0d rdata=%h expected 0/a0000005", stray, dm_rdata_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] addr, wdata;
    logic        we;
    bit          ok;
    int          n;
    int          acks;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h400;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_mid_pre: mem_req_o=%b expected 1", mem_req_o);
    end
    rst_i = 1'b1;
    #1;
    total++;
    if ({mem_req_o, mem_we_o, dm_ack_o, if_ack_o, err_o} !== 5'b0 || dm_rdata_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_mid_async: ctrl=%b rdata=%h expected 00000/00000000",
               {mem_req_o, mem_we_o, dm_ack_o, if_ack_o, err_o}, dm_rdata_o);
    end
    dm_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    acks = 0;
    repeat (4) begin
      tick();
      if (dm_ack_o === 1'b1) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("[TB] FAIL rst_mid_no_ack: %0d dm acks expected 0", acks);
    end
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    serve(32'h5555AAAA, 3, addr, we, wdata, ok);
    total++;
    if (!ok || addr !== 32'h500 || if_ack_o !== 1'b1 || if_rdata_o !== 32'h5555AAAA || err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid_recover: ok=%0d addr=%h ack=%b rdata=%h err=%b expected 1/00000500/1/5555aaaa/0",
               ok, addr, if_ack_o, if_rdata_o, err_o);
    end
    if_req_i = 1'b0;
    repeat (2) tick();
  endtask

  // Fastest memory: ack in the cycle after mem_req_o rises. The requester
  // then samples if_ack_o high on the third rising edge after the one that
  // raised mem_req_o.
  task automatic test_one_cycle();
    int n;
    if_req_i  = 1'b1;
    if_addr_i = 32'h600;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (mem_req_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fast_grant: mem_req_o=%b expected 1", mem_req_o);
    end
    tick();
    total++;
    if (if_ack_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fast_no_early_ack: if_ack_o=%b expected 0", if_ack_o);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0BADF00D;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h0BADF00D) begin
      bad++;
      $display("[TB] FAIL fast_ack: ack=%b rdata=%h expected 1/0badf00d", if_ack_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    tick();
    total++;
    if (if_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fast_ack_end: ack=%b req=%b expected 0/0", if_ack_o, mem_req_o);
    end
  endtask

  // Runs every scenario in order and prints the single summary line.
  initial begin
    test_reset();
    test_if_read();
    test_same_cycle();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_one_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a hung scenario.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
